wb_bus_arbiter: RTL and testbench

Two-master, one-slave Wishbone (classic, B4) arbiter. It shares the core's single peripheral/data bus between the memory stage (master 0, data port) and instruction fetch (master 1). It grants round-robin with burst locking, enforces a bus timeout, and produces per-master stall signals that feed the pipeline's peripheral-stall network. It sits between the pipeline's bus masters and the peripheral interconnect (UART FIFO registers, data RAM).

---
 rtl/wb_bus_arbiter_pkg.sv | 38 +++
 rtl/wb_timeout_counter.sv | 44 ++++
 rtl/wb_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_bus_arbiter_pkg
//  Description : Shared state encodings, grant encodings and the round-robin
//                pick function for the two-master Wishbone arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_bus_arbiter_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_GNT0 = 2'd1;
    localparam logic [1:0] ARB_GNT1 = 2'd2;

    // One-hot grant encodings presented on grant_o, {m1, m0}
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Round-robin choice: a lone requester wins; on a tie the master that
    // was not granted last wins.
    function automatic logic [1:0] arb_pick(
        input logic req0,
        input logic req1,
        input logic last
    );
        if (req0 && req1) begin
            return last ? ARB_GNT0 : ARB_GNT1;
        end else if (req0) begin
            return ARB_GNT0;
        end else if (req1) begin
            return ARB_GNT1;
        end
        return ARB_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timeout_counter
//  Description : Counts unanswered strobe cycles of the granted master and
//                raises a single-cycle expire pulse on the last allowed
//                cycle. TIMEOUT_CYCLES = 0 disables expiry entirely.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt =
        (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit c_enabled = (TIMEOUT_CYCLES > 0);

    logic [c_cnt_w-1:0] r_count;

    // Expiry fires in the cycle that would be the TIMEOUT_CYCLES-th
    // unanswered strobe; i_enable already excludes ack/err cycles.
    assign o_expire = c_enabled & i_enable & (r_count == c_last_cnt);

    // Count unanswered strobe cycles; restart on response, grant change or expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_expire) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_bus_arbiter
//  Description : Two-master / one-slave Wishbone classic arbiter. Round-robin
//                grant with burst lock on cyc, bus timeout, combinational
//                request/response muxing and per-master pipeline stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // master 0 (data port)
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic                m0_stall_o,
    // master 1 (fetch port)
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                m1_stall_o,
    // slave side
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    // status
    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last;
    logic       w_req0;
    logic       w_req1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_expire;
    logic       w_cnt_en;
    logic       w_cnt_clr;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;
    assign w_gnt0 = (r_state == ARB_GNT0);
    assign w_gnt1 = (r_state == ARB_GNT1);

    // Timeout bookkeeping: count strobe cycles of the owner that get no
    // response, restart whenever the slave answers or ownership moves.
    assign w_cnt_en  = ((w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i)) & ~s_ack_i & ~s_err_i;
    assign w_cnt_clr = s_ack_i | s_err_i | (w_state_nxt != r_state);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_clear  (w_cnt_clr),
        .i_enable (w_cnt_en),
        .o_expire (w_expire)
    );

    // Next-state: hold the owner while its cyc is high, otherwise re-arbitrate
    // in the same cycle; a timeout always sends the FSM back to idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                w_state_nxt = arb_pick(w_req0, w_req1, r_last);
            end
            ARB_GNT0: begin
                if (w_expire) begin
                    w_state_nxt = ARB_IDLE;
                end else if (!m0_cyc_i) begin
                    w_state_nxt = arb_pick(w_req0, w_req1, r_last);
                end
            end
            ARB_GNT1: begin
                if (w_expire) begin
                    w_state_nxt = ARB_IDLE;
                end else if (!m1_cyc_i) begin
                    w_state_nxt = arb_pick(w_req0, w_req1, r_last);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State and last-granted register; last tracks whichever master owns the bus
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ARB_GNT0) begin
                r_last <= 1'b0;
            end else if (w_state_nxt == ARB_GNT1) begin
                r_last <= 1'b1;
            end
        end
    end

    // Request mux toward the slave and response demux back to the owner only
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (w_gnt0) begin
            s_cyc_o  = m0_cyc_i & ~w_expire;
            s_stb_o  = m0_stb_i & ~w_expire;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | w_expire;
            m0_dat_o = s_dat_i;
        end else if (w_gnt1) begin
            s_cyc_o  = m1_cyc_i & ~w_expire;
            s_stb_o  = m1_stb_i & ~w_expire;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | w_expire;
            m1_dat_o = s_dat_i;
        end
    end

    // A requesting master stalls unless it owns the bus and gets a response
    assign m0_stall_o = w_req0 & ~(w_gnt0 & (s_ack_i | s_err_i | w_expire));
    assign m1_stall_o = w_req1 & ~(w_gnt1 & (s_ack_i | s_err_i | w_expire));

    assign grant_o   = w_gnt1 ? GRANT_M1 : (w_gnt0 ? GRANT_M0 : GRANT_NONE);
    assign timeout_o = w_expire;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_bus_arbiter
//  Description : Self-checking bench for wb_bus_arbiter. Two instances share
//                all inputs: one with TIMEOUT_CYCLES=8, one with the timeout
//                disabled. Every cycle both are compared against a
//                transaction-level ownership model; directed steps add
//                explicit checks for the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        s_ack, s_err;

    logic [1:0][31:0] o_m0_dat, o_m1_dat, o_s_adr, o_s_dat;
    logic [1:0][3:0]  o_s_sel;
    logic [1:0][1:0]  o_grant;
    logic [1:0]       o_m0_ack, o_m0_err, o_m0_stall, o_m1_ack, o_m1_err, o_m1_stall;
    logic [1:0]       o_s_cyc, o_s_stb, o_s_we, o_timeout;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_bus_arbiter #(
            .ADDR_W         (32),
            .DATA_W         (32),
            .TIMEOUT_CYCLES ((g == 0) ? 8 : 0)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst_i),
            .m0_cyc_i   (m0_cyc),
            .m0_stb_i   (m0_stb),
            .m0_we_i    (m0_we),
            .m0_adr_i   (m0_adr),
            .m0_dat_i   (m0_dat),
            .m0_sel_i   (m0_sel),
            .m0_dat_o   (o_m0_dat[g]),
            .m0_ack_o   (o_m0_ack[g]),
            .m0_err_o   (o_m0_err[g]),
            .m0_stall_o (o_m0_stall[g]),
            .m1_cyc_i   (m1_cyc),
            .m1_stb_i   (m1_stb),
            .m1_we_i    (m1_we),
            .m1_adr_i   (m1_adr),
            .m1_dat_i   (m1_dat),
            .m1_sel_i   (m1_sel),
            .m1_dat_o   (o_m1_dat[g]),
            .m1_ack_o   (o_m1_ack[g]),
            .m1_err_o   (o_m1_err[g]),
            .m1_stall_o (o_m1_stall[g]),
            .s_cyc_o    (o_s_cyc[g]),
            .s_stb_o    (o_s_stb[g]),
            .s_we_o     (o_s_we[g]),
            .s_adr_o    (o_s_adr[g]),
            .s_dat_o    (o_s_dat[g]),
            .s_sel_o    (o_s_sel[g]),
            .s_dat_i    (s_dat),
            .s_ack_i    (s_ack),
            .s_err_i    (s_err),
            .grant_o    (o_grant[g]),
            .timeout_o  (o_timeout[g])
        );
    end

    // Reference model: owner (-1 none, 0, 1), last granted master, and the
    // number of unanswered strobe cycles since ownership/last response.
    int md_to [2] = '{8, 0};
    int md_owner [2];
    int md_last  [2];
    int md_wait  [2];
    int md_nowner[2];
    int md_nlast [2];
    int md_nwait [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL d%0d.%s observed=%0h expected=%0h", d, tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        md_owner[d] = -1;
        md_last[d]  = 1;
        md_wait[d]  = 0;
    endtask

    // Compare both instances against the model at the falling edge and
    // prepare the model's next state from the inputs held through the edge.
    task automatic sample();
        bit [1:0] cyc, stb, we;
        bit expire, req0, req1;
        int o, n;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        @(negedge clk);
        cyc = {m1_cyc, m0_cyc};
        stb = {m1_stb, m0_stb};
        we  = {m1_we, m0_we};
        for (int d = 0; d < 2; d++) begin
            o = md_owner[d];
            expire = (md_to[d] > 0) && (o >= 0) && stb[o] && !s_ack && !s_err
                     && (md_wait[d] + 1 == md_to[d]);
            e_adr = (o == 0) ? m0_adr : (o == 1) ? m1_adr : 32'h0;
            e_dat = (o == 0) ? m0_dat : (o == 1) ? m1_dat : 32'h0;
            e_sel = (o == 0) ? m0_sel : (o == 1) ? m1_sel : 4'h0;
            chk(d, "grant",    o_grant[d],    (o < 0) ? 2'b00 : (o == 0) ? 2'b01 : 2'b10);
            chk(d, "timeout",  o_timeout[d],  expire);
            chk(d, "s_cyc",    o_s_cyc[d],    (o >= 0) && cyc[o] && !expire);
            chk(d, "s_stb",    o_s_stb[d],    (o >= 0) && stb[o] && !expire);
            chk(d, "s_we",     o_s_we[d],     (o >= 0) && we[o]);
            chk(d, "s_adr",    o_s_adr[d],    e_adr);
            chk(d, "s_dat",    o_s_dat[d],    e_dat);
            chk(d, "s_sel",    o_s_sel[d],    e_sel);
            chk(d, "m0_ack",   o_m0_ack[d],   (o == 0) && s_ack);
            chk(d, "m1_ack",   o_m1_ack[d],   (o == 1) && s_ack);
            chk(d, "m0_err",   o_m0_err[d],   (o == 0) && (s_err || expire));
            chk(d, "m1_err",   o_m1_err[d],   (o == 1) && (s_err || expire));
            chk(d, "m0_dat",   o_m0_dat[d],   (o == 0) ? s_dat : 32'h0);
            chk(d, "m1_dat",   o_m1_dat[d],   (o == 1) ? s_dat : 32'h0);
            chk(d, "m0_stall", o_m0_stall[d], cyc[0] && stb[0] && !((o == 0) && (s_ack || s_err || expire)));
            chk(d, "m1_stall", o_m1_stall[d], cyc[1] && stb[1] && !((o == 1) && (s_ack || s_err || expire)));
            req0 = cyc[0] && stb[0];
            req1 = cyc[1] && stb[1];
            if (expire) n = -1;
            else if (o >= 0 && cyc[o]) n = o;
            else if (req0 && req1) n = 1 - md_last[d];
            else if (req0) n = 0;
            else if (req1) n = 1;
            else n = -1;
            md_nowner[d] = n;
            md_nlast[d]  = (n >= 0) ? n : md_last[d];
            if (n != o || s_ack || s_err) md_nwait[d] = 0;
            else if (o >= 0 && stb[o]) md_nwait[d] = md_wait[d] + 1;
            else md_nwait[d] = md_wait[d];
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst_i) begin
                model_reset(d);
            end else begin
                md_owner[d] = md_nowner[d];
                md_last[d]  = md_nlast[d];
                md_wait[d]  = md_nwait[d];
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic m0_set(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] dt);
        m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat = dt; m0_sel = 4'hF;
    endtask

    task automatic m1_set(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] dt);
        m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat = dt; m1_sel = 4'hF;
    endtask

    initial begin
        int k, hit, n_to1, n_err1;
        rst_i = 1'b1;
        m0_set(0, 0, 0, 0, 0);
        m1_set(0, 0, 0, 0, 0);
        s_dat = 32'h0; s_ack = 1'b0; s_err = 1'b0;
        advance();
        advance();
        rst_i = 1'b0;

        // Reset state
        sample();
        chk(0, "rst_grant", o_grant[0], 2'b00);
        chk(0, "rst_s_cyc", o_s_cyc[0], 1'b0);
        advance();

        // Tie after reset: m0 first, m1 after m0 drops cyc
        m0_set(1, 1, 0, 32'h2000_0000, 32'h11);
        m1_set(1, 1, 0, 32'h0000_0100, 32'h22);
        step();
        s_ack = 1'b1; s_dat = 32'hCAFE_0001;
        sample();
        chk(0, "tie_first_m0", o_grant[0], 2'b01);
        chk(0, "tie_m0_ack", o_m0_ack[0], 1'b1);
        chk(0, "tie_m1_stall", o_m1_stall[0], 1'b1);
        advance();
        s_ack = 1'b0;
        m0_set(0, 0, 0, 0, 0);
        sample();
        chk(0, "tie_hold_m0", o_grant[0], 2'b01);
        advance();
        s_ack = 1'b1; s_dat = 32'hCAFE_0002;
        sample();
        chk(0, "tie_then_m1", o_grant[0], 2'b10);
        chk(0, "tie_m1_ack", o_m1_ack[0], 1'b1);
        chk(0, "tie_m0_noack", o_m0_ack[0], 1'b0);
        advance();
        s_ack = 1'b0;
        m1_set(0, 0, 0, 0, 0);
        step();
        m0_set(1, 1, 0, 32'h2000_0004, 32'h33);
        m1_set(1, 1, 0, 32'h0000_0104, 32'h44);
        step();
        sample();
        chk(0, "tie2_m0", o_grant[0], 2'b01);
        advance();
        m0_set(0, 0, 0, 0, 0);
        m1_set(0, 0, 0, 0, 0);
        step();
        step();

        // m0 single write to a zero-wait slave
        m0_set(1, 1, 1, 32'h1000_0000, 32'h0000_00A5);
        sample();
        chk(0, "wr_req_s_cyc", o_s_cyc[0], 1'b0);
        advance();
        s_ack = 1'b1;
        sample();
        chk(0, "wr_s_cyc", o_s_cyc[0], 1'b1);
        chk(0, "wr_s_we", o_s_we[0], 1'b1);
        chk(0, "wr_s_adr", o_s_adr[0], 32'h1000_0000);
        chk(0, "wr_s_dat", o_s_dat[0], 32'h0000_00A5);
        chk(0, "wr_m0_ack", o_m0_ack[0], 1'b1);
        chk(0, "wr_m1_ack", o_m1_ack[0], 1'b0);
        advance();
        s_ack = 1'b0;
        m0_set(0, 0, 0, 0, 0);
        step();

        // m1 4-beat burst while m0 waits
        m1_set(1, 1, 0, 32'h0000_0200, 32'h0);
        step();
        m0_set(1, 1, 0, 32'h1000_0010, 32'h55);
        s_ack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_dat = 32'hB000_0000 + b;
            m1_adr = 32'h0000_0200 + 4 * b;
            sample();
            chk(0, "burst_grant", o_grant[0], 2'b10);
            chk(0, "burst_m0_stall", o_m0_stall[0], 1'b1);
            chk(0, "burst_m1_ack", o_m1_ack[0], 1'b1);
            advance();
        end
        s_ack = 1'b0;
        m1_set(0, 0, 0, 0, 0);
        sample();
        chk(0, "burst_end_stall", o_m0_stall[0], 1'b1);
        advance();
        sample();
        chk(0, "burst_handover", o_grant[0], 2'b01);
        advance();
        m0_set(0, 0, 0, 0, 0);
        step();
        step();

        // Timeout on the 8th unanswered strobe cycle
        m0_set(1, 1, 0, 32'h1000_0020, 32'h0);
        step();
        hit = 0;
        for (k = 1; k <= 20; k++) begin
            sample();
            if (o_timeout[0]) begin
                chk(0, "to_cycle", k, 8);
                chk(0, "to_s_cyc", o_s_cyc[0], 1'b0);
                chk(0, "to_m0_err", o_m0_err[0], 1'b1);
                hit = 1;
                advance();
                break;
            end
            advance();
        end
        chk(0, "to_seen", hit, 1);
        sample();
        chk(0, "to_idle", o_grant[0], 2'b00);
        advance();
        m0_set(0, 0, 0, 0, 0);
        step();
        step();

        // Ack landing exactly in the timeout cycle wins
        m0_set(1, 1, 0, 32'h1000_0030, 32'h0);
        step();
        for (int b = 0; b < 7; b++) step();
        s_ack = 1'b1;
        sample();
        chk(0, "ackto_ack", o_m0_ack[0], 1'b1);
        chk(0, "ackto_err", o_m0_err[0], 1'b0);
        chk(0, "ackto_timeout", o_timeout[0], 1'b0);
        advance();
        s_ack = 1'b0;
        m0_set(0, 0, 0, 0, 0);
        step();
        step();

        // Timeout disabled: no error over 1000 unanswered cycles
        m0_set(1, 1, 0, 32'h1000_0040, 32'h0);
        n_to1 = 0;
        n_err1 = 0;
        for (int b = 0; b < 1000; b++) begin
            sample();
            n_to1  += int'(o_timeout[1]);
            n_err1 += int'(o_m0_err[1]);
            advance();
        end
        sample();
        chk(1, "nto_timeouts", n_to1, 0);
        chk(1, "nto_errs", n_err1, 0);
        chk(1, "nto_grant", o_grant[1], 2'b01);
        advance();
        m0_set(0, 0, 0, 0, 0);
        step();
        step();

        // Reset pulsed during a stalled transfer
        m0_set(1, 1, 1, 32'h1000_0050, 32'h77);
        step();
        step();
        step();
        rst_i = 1'b1;
        sample();
        chk(0, "rstmid_stall", o_m0_stall[0], 1'b1);
        advance();
        rst_i = 1'b0;
        sample();
        chk(0, "rstmid_grant", o_grant[0], 2'b00);
        chk(0, "rstmid_s_cyc", o_s_cyc[0], 1'b0);
        chk(0, "rstmid_m0_ack", o_m0_ack[0], 1'b0);
        chk(0, "rstmid_stall_req", o_m0_stall[0], 1'b1);
        advance();
        s_ack = 1'b1;
        sample();
        chk(0, "rstmid_regrant", o_grant[0], 2'b01);
        chk(0, "rstmid_reack", o_m0_ack[0], 1'b1);
        advance();
        s_ack = 1'b0;
        m0_set(0, 0, 0, 0, 0);
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            if (!m0_cyc) m0_cyc = ($urandom_range(2) == 0);
            else if ($urandom_range(3) == 0) m0_cyc = 1'b0;
            if (!m1_cyc) m1_cyc = ($urandom_range(2) == 0);
            else if ($urandom_range(3) == 0) m1_cyc = 1'b0;
            m0_stb = m0_cyc & ($urandom_range(3) != 0);
            m1_stb = m1_cyc & ($urandom_range(3) != 0);
            m0_we  = 1'($urandom);
            m1_we  = 1'($urandom);
            m0_adr = $urandom;
            m1_adr = $urandom;
            m0_dat = $urandom;
            m1_dat = $urandom;
            m0_sel = 4'($urandom);
            m1_sel = 4'($urandom);
            s_dat  = $urandom;
            s_ack  = ($urandom_range(9) < 3);
            s_err  = ($urandom_range(19) == 0);
            rst_i  = ($urandom_range(299) == 0);
            step();
        end
        rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
